// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : resolves branch/jump outcome and target against the front-end
//            prediction, one registered result stage with valid/ready.
// Revision : 1.0
// ============================================================================
module branch_resolve #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  REG1,
   input  logic [XLEN-1:0]  REG2,
   input  logic [2:0]       Type,
   input  logic             is_jal,
   input  logic             is_jalr,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic             pred_taken,
   input  logic [XLEN-1:0]  pred_target,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             BrE,
   output logic [XLEN-1:0]  target,
   output logic [XLEN-1:0]  link,
   output logic             mispredict,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mp_count
);

   localparam logic [XLEN-1:0]  c_four    = XLEN'(4);
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic             r_out_valid;
   logic             r_bre;
   logic [XLEN-1:0]  r_target;
   logic [XLEN-1:0]  r_link;
   logic             r_mispredict;
   logic [CNT_W-1:0] r_br_count;
   logic [CNT_W-1:0] r_mp_count;

   logic             w_eq;
   logic             w_lt_s;
   logic             w_lt_u;
   logic             w_cond;
   logic             w_taken;
   logic [XLEN-1:0]  w_jalr_sum;
   logic [XLEN-1:0]  w_pc_imm;
   logic [XLEN-1:0]  w_link;
   logic [XLEN-1:0]  w_target;
   logic             w_mispredict;
   logic             w_accept;

   assign w_eq   = (REG1 == REG2);
   assign w_lt_s = ($signed(REG1) < $signed(REG2));
   assign w_lt_u = (REG1 < REG2);

   always_comb begin
      w_cond = 1'b0;
      case (Type)
         3'b010:  w_cond = w_eq;
         3'b001:  w_cond = !w_eq;
         3'b100:  w_cond = w_lt_s;
         3'b101:  w_cond = !w_lt_s;
         3'b110:  w_cond = w_lt_u;
         3'b111:  w_cond = !w_lt_u;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_taken    = is_jal | is_jalr | w_cond;
   assign w_jalr_sum = REG1 + imm;
   assign w_pc_imm   = pc + imm;
   assign w_link     = pc + c_four;

   // is_jalr wins when both jump modes are raised
   always_comb begin
      w_target = w_link;
      if (is_jalr)
         w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      else if (w_taken)
         w_target = w_pc_imm;
   end

   // the predicted target only matters when the branch is actually taken
   assign w_mispredict = (w_taken != pred_taken) | (w_taken & (w_target != pred_target));

   assign in_ready = !r_out_valid | out_ready;
   assign w_accept = in_valid & in_ready & !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_bre        <= 1'b0;
         r_target     <= '0;
         r_link       <= '0;
         r_mispredict <= 1'b0;
         r_br_count   <= '0;
         r_mp_count   <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_bre        <= w_taken;
         r_target     <= w_target;
         r_link       <= w_link;
         r_mispredict <= w_mispredict;
         if (r_br_count != c_cnt_max)
            r_br_count <= r_br_count + c_cnt_one;
         if (w_mispredict && (r_mp_count != c_cnt_max))
            r_mp_count <= r_mp_count + c_cnt_one;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign BrE        = r_bre;
   assign target     = r_target;
   assign link       = r_link;
   assign mispredict = r_mispredict;
   assign br_count   = r_br_count;
   assign mp_count   = r_mp_count;

endmodule
`default_nettype wire
